// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: wait-state memory responder for the CPU req/ready bus handshake
// Ports: clk, reset (sync, active-high); req/we/addr/wdata request sampled in IDLE;
//        rdata registered read data; ready one-cycle completion pulse; busy from
//        acceptance until IDLE; err (only with MEM_ERR_EN) flags out-of-range access.
// Optional feature macro: MEM_ERR_EN (address range checking with err output).
module cpu_mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy
`ifdef MEM_ERR_EN
    ,
    output logic              err
`endif
);
    localparam int IDX_W = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              go_resp, in_range;
    // The _d request fields equal the live inputs on acceptance and the latched
    // copies afterwards, so they are the right operands on the edge entering RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                cnt_d   = 8'(WAIT_CYCLES);
                we_d    = we;
                addr_d  = addr;
                wdata_d = wdata;
            end
            WAIT: begin
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q == 8'd1) ? RESP : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end
    assign go_resp = (state_d == RESP) && (state_q != RESP);
`ifdef MEM_ERR_EN
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
    assign in_range = {1'b0, addr_d} < LIMIT;
    assign err      = ready && ({1'b0, addr_q} >= LIMIT);
`else
    logic unused_hi;
    assign in_range  = 1'b1;
    assign unused_hi = ^addr_d;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (go_resp && !we_d) rdata_q <= in_range ? mem_q[addr_d[IDX_W-1:0]] : '0;
        end
    end
    // Storage is not reset; a reset edge still cancels a write about to commit.
    always_ff @(posedge clk) begin
        if (!reset && go_resp && we_d && in_range) mem_q[addr_d[IDX_W-1:0]] <= wdata_d;
    end
    assign rdata = rdata_q;
    assign ready = state_q == RESP;
    assign busy  = state_q != IDLE;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: scoreboard bench for cpu_mem_responder at WAIT_CYCLES 0 and 2
module tb_cpu_mem_responder;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req_r [2], we_r [2];
    logic [7:0]  addr_r [2];
    logic [15:0] wdata_r [2], rdata_w [2];
    logic        ready_w [2], busy_w [2];
`ifdef MEM_ERR_EN
    logic        err_w [2];
`endif
    typedef struct {logic rd; logic [15:0] data; logic er; int due;} exp_t;
    exp_t q0[$], q1[$];
    int   cyc = 0, n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .req(req_r[0]), .we(we_r[0]), .addr(addr_r[0]),
        .wdata(wdata_r[0]), .rdata(rdata_w[0]), .ready(ready_w[0]), .busy(busy_w[0])
`ifdef MEM_ERR_EN
        , .err(err_w[0])
`endif
    );
    cpu_mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(reset), .req(req_r[1]), .we(we_r[1]), .addr(addr_r[1]),
        .wdata(wdata_r[1]), .rdata(rdata_w[1]), .ready(ready_w[1]), .busy(busy_w[1])
`ifdef MEM_ERR_EN
        , .err(err_w[1])
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   got;
        if (!reset) for (int i = 0; i < 2; i++) if (ready_w[i]) begin
            got = 0;
            if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1; end
            if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
            if (!got) chk("spurious_ready", 1, 0);
            else begin
                chk("latency", cyc, e.due);
                chk("busy_with_ready", {31'b0, busy_w[i]}, 1);
                if (e.rd) chk("rdata", {16'b0, rdata_w[i]}, {16'b0, e.data});
`ifdef MEM_ERR_EN
                chk("err", {31'b0, err_w[i]}, {31'b0, e.er});
`endif
            end
        end
    end

    // One CPU transaction: hold req until ready is seen, optionally misbehaving
    // (dropping req and scrambling the request fields) right after acceptance.
    task automatic txn(input int i, input logic w, input logic [7:0] a, input logic [15:0] d,
                       input logic [15:0] ed, input logic ee, input bit glitch);
        exp_t e;
        bit   seen;
        e.rd = !w; e.data = ed; e.er = ee; e.due = cyc + ((i == 0) ? 0 : 2) + 1;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        req_r[i] = 1'b1; we_r[i] = w; addr_r[i] = a; wdata_r[i] = d;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(posedge clk); #1;
            if (glitch && k == 0) begin
                req_r[i] = 1'b0; we_r[i] = ~w; addr_r[i] = ~a; wdata_r[i] = ~d;
            end
            seen = ready_w[i];
        end
        if (!seen) chk("ready_timeout", 0, 1);
        req_r[i] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_r[i] = 1'b0; we_r[i] = 1'b0; addr_r[i] = '0; wdata_r[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                chk("idle_ready", {31'b0, ready_w[i]}, 0);
                chk("idle_busy", {31'b0, busy_w[i]}, 0);
                chk("idle_rdata", {16'b0, rdata_w[i]}, 0);
            end
        end
        txn(1, 1, 8'h05, 16'hBEEF, 16'h0, 0, 0);
        txn(1, 0, 8'h05, 16'h0, 16'hBEEF, 0, 0);
        @(posedge clk); #1;
        chk("rdata_hold", {16'b0, rdata_w[1]}, 32'hBEEF);
        txn(1, 1, 8'h06, 16'h1357, 16'h0, 0, 0);
        chk("write_keeps_rdata", {16'b0, rdata_w[1]}, 32'hBEEF);
        txn(1, 0, 8'h06, 16'h0, 16'h1357, 0, 1);
        txn(1, 1, 8'h08, 16'h2468, 16'h0, 0, 1);
        txn(1, 0, 8'h08, 16'h0, 16'h2468, 0, 0);
        txn(0, 1, 8'h10, 16'h1234, 16'h0, 0, 0);
        txn(0, 0, 8'h10, 16'h0, 16'h1234, 0, 0);
`ifdef MEM_ERR_EN
        txn(0, 0, 8'h83, 16'h0, 16'h0000, 1, 0);
        txn(0, 1, 8'h90, 16'hFFFF, 16'h0, 1, 0);
        txn(0, 0, 8'h10, 16'h0, 16'h1234, 0, 0);
`else
        txn(0, 1, 8'h83, 16'h00C3, 16'h0, 0, 0);
        txn(0, 0, 8'h03, 16'h0, 16'h00C3, 0, 0);
`endif
        txn(1, 1, 8'h07, 16'h5555, 16'h0, 0, 0);
        req_r[1] = 1'b1; we_r[1] = 1'b1; addr_r[1] = 8'h07; wdata_r[1] = 16'hAAAA;
        @(posedge clk); #1;
        chk("busy_in_wait", {31'b0, busy_w[1]}, 1);
        reset = 1'b1; req_r[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("busy_after_reset", {31'b0, busy_w[1]}, 0);
        chk("rdata_after_reset", {16'b0, rdata_w[1]}, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("no_ready_after_reset", {31'b0, ready_w[1]}, 0);
        end
        txn(1, 0, 8'h07, 16'h0, 16'h5555, 0, 0);
        repeat (2) @(posedge clk);
        #1 chk("pending_responses", q0.size() + q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
